dot_row_serializer: RTL and testbench
=====================================

# dot_row_serializer

Downstream stage of the 16x16 dot-matrix scanner: accepts one 16-bit row pattern plus its 4-bit row index per handshake and shifts it MSB-first into the panel's serial column shift registers (595-style: data, shift clock, storage latch). It drives the row-select address and output-enable. The panel row changes only at the latch, so no half-shifted pattern is ever displayed. An optional blanking window around the latch suppresses ghosting between rows.

## Interface
- `CLK_DIV`, default 2: `clk` cycles per shift-clock half-period (≥1).
- `BLANK_CYCLES`, default 4: `oe_n` high cycles before the latch (≥1; used only with blanking compiled in).
- `clk` input, 1 bit: single clock, all logic on rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_data` input, 16 bits: row pattern; bit 15 is shifted first.
- `in_sel` input, 4 bits: row index for `in_data`.
- `in_valid` input, 1 bit: upstream holds `in_data`/`in_sel` stable while high.
- `in_ready` output, 1 bit: block is idle and can accept.
- `ser_dout` output, 1 bit: serial column data.
- `ser_clk` output, 1 bit: shift clock; the panel samples on its rising edge.
- `ser_latch` output, 1 bit: storage-register latch pulse.
- `oe_n` output, 1 bit: panel output enable, active low.
- `row_addr` output, 4 bits: row decoder address.
- `frame_done` output, 1 bit: 1-cycle pulse when row 15 is latched.

## Operation
- Reset values:
  - `in_ready`=1.
  - `ser_dout`=0, `ser_clk`=0, `ser_latch`=0.
  - `oe_n`=1; the panel stays dark until the first latch.
  - `row_addr`=0, `frame_done`=0.
  - State is IDLE.
- FSM states: IDLE → SHIFT → BLANK → LATCH → IDLE.
- IDLE:
  - `in_ready`=1.
  - An edge with `in_valid`&&`in_ready` captures `in_data` into a shift reg and `in_sel` into a sel reg, then moves to SHIFT.
  - `in_ready` drops on the same edge.
- SHIFT:
  - Runs 16 bits. Per bit: `ser_dout` = shift reg bit 15, `ser_clk`=0 for CLK_DIV cycles, then `ser_clk`=1 for CLK_DIV cycles.
  - The shift reg shifts left by one as `ser_clk` falls back low.
  - A 4-bit counter wraps 15→0 and exits to BLANK.
  - `oe_n` is unchanged, so the previous row keeps displaying.
- BLANK: `oe_n`=1 for BLANK_CYCLES cycles, `ser_clk`=0, then LATCH.
- LATCH:
  - `ser_latch`=1 for CLK_DIV cycles.
  - `row_addr` loads the sel reg on the edge entering LATCH.
  - `frame_done` pulses on that same edge if the sel reg is 15.
- Exit from LATCH:
  - `ser_latch`=0, `oe_n`=0, `in_ready`=1, state returns to IDLE.
- `in_valid` while busy is ignored. No data is lost, because upstream holds its data until accepted.
- Counter widths: divider counter is clog2(CLK_DIV+1) bits; blank counter is clog2(BLANK_CYCLES+1) bits. Counters reset to 0 on each state entry.
- Reset asserted mid-operation aborts immediately: all outputs return to reset values and the partial shift is discarded. After release, the next accepted row restarts from bit 15.
- `ser_dout` changes only while `ser_clk`=0, giving ≥CLK_DIV cycles of setup and hold around each rising edge.

## Timing
- Accept edge T. SHIFT occupies cycles T+1 … T+32·CLK_DIV.
- BLANK occupies the next BLANK_CYCLES cycles. LATCH occupies the next CLK_DIV cycles.
- `in_ready` and `oe_n` return (1 and 0 respectively) at T+33·CLK_DIV+BLANK_CYCLES+1.
- Defaults: T+71, giving a throughput of one row per 71 cycles, since the next accept is that same cycle if `in_valid`.
- Without blanking: T+33·CLK_DIV+1, i.e. T+67 at defaults.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `DOT_ROW_BLANK_EN` defined:
  - BLANK state is present.
  - `oe_n`=1 throughout BLANK and LATCH.
  - `oe_n` goes low on return to IDLE.
- Not defined:
  - BLANK state is removed; SHIFT goes directly to LATCH.
  - `oe_n` is 1 from reset until the first latch completes, then held 0.
  - BLANK_CYCLES is unused.

## Test plan
- Reset, then idle:
  - Outputs equal reset values: `oe_n`=1, `row_addr`=0, `in_ready`=1.
  - No `ser_clk` edges over 200 cycles.
- Send `in_data`=16'hFFA4, `in_sel`=3 with defaults:
  - Exactly 16 `ser_clk` rises, with `ser_dout` sampled at rises = 1111_1111_1010_0100.
  - `ser_latch` high for 2 cycles, `row_addr`=3.
  - `in_ready` high again at T+71.
- Hold `in_valid` high across 16 rows with `in_sel` 0…15:
  - Back-to-back accepts every 71 cycles.
  - `frame_done` exactly once, at the row-15 latch.
  - `row_addr` sequence 0…15.
- Toggle `in_valid` and `in_data` mid-SHIFT:
  - The shifted bits and `row_addr` reflect only the captured values.
  - No extra accept occurs.
- Assert `rst_n` low at bit 7 of SHIFT:
  - Outputs reach reset values asynchronously.
  - After release, a new row 16'h0024 shifts completely and latches correctly.
- `DOT_ROW_BLANK_EN` undefined, `CLK_DIV`=1:
  - Row accepted at T gives `in_ready` at T+34.
  - `oe_n` stays 0 after the first latch; there are no BLANK cycles.

Source files
------------

// File: rtl/dot_row_serializer.sv
// Row serializer for the 16x16 dot-matrix panel: shifts one 16-bit row MSB-first into 595-style column registers.
// Optional pre-latch blanking window compiled in with `define DOT_ROW_BLANK_EN.
module dot_row_serializer #(
  parameter int CLK_DIV      = 2,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_sel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        ser_dout,
  output logic        ser_clk,
  output logic        ser_latch,
  output logic        oe_n,
  output logic [3:0]  row_addr,
  output logic        frame_done
);

`ifdef DOT_ROW_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, BLANK, LATCH} state_t;

  state_t        state, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   sreg_q, sreg_d;
  logic [3:0]    sel_q, sel_d;
  logic          dout_d, sclk_d, latch_d, oe_d, frame_d, ready_d;
  logic [3:0]    row_d;
  logic          enter_latch;

  always_comb begin
    state_d     = state;
    div_d       = div_q;
    bcnt_d      = bcnt_q;
    bit_d       = bit_q;
    sreg_d      = sreg_q;
    sel_d       = sel_q;
    dout_d      = ser_dout;
    sclk_d      = ser_clk;
    latch_d     = ser_latch;
    oe_d        = oe_n;
    row_d       = row_addr;
    frame_d     = 1'b0;
    ready_d     = in_ready;
    enter_latch = 1'b0;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        sreg_d  = in_data;
        sel_d   = in_sel;
        dout_d  = in_data[15];
        sclk_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        ready_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!ser_clk) sclk_d = 1'b1;
          else begin
            // next bit presented on the falling shift-clock edge only
            sclk_d = 1'b0;
            sreg_d = {sreg_q[14:0], 1'b0};
            dout_d = sreg_q[14];
            bit_d  = bit_q + 4'd1;
            if (bit_q == 4'd15) begin
              if (BLANK_EN) begin
                state_d = BLANK;
                bcnt_d  = '0;
                oe_d    = 1'b1;
              end else enter_latch = 1'b1;
            end
          end
        end else div_d = div_q + 1'b1;
      end
      BLANK: begin
        if (bcnt_q == BLANK_LAST) enter_latch = 1'b1;
        else bcnt_d = bcnt_q + 1'b1;
      end
      LATCH: begin
        if (div_q == DIV_LAST) begin
          latch_d = 1'b0;
          oe_d    = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end else div_d = div_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // row address moves with the latch so the panel never shows a half-shifted row
    if (enter_latch) begin
      state_d = LATCH;
      div_d   = '0;
      latch_d = 1'b1;
      row_d   = sel_q;
      frame_d = (sel_q == 4'd15);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_q      <= '0;
      bcnt_q     <= '0;
      bit_q      <= '0;
      sreg_q     <= '0;
      sel_q      <= '0;
      ser_dout   <= 1'b0;
      ser_clk    <= 1'b0;
      ser_latch  <= 1'b0;
      oe_n       <= 1'b1;
      row_addr   <= '0;
      frame_done <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_d;
      div_q      <= div_d;
      bcnt_q     <= bcnt_d;
      bit_q      <= bit_d;
      sreg_q     <= sreg_d;
      sel_q      <= sel_d;
      ser_dout   <= dout_d;
      ser_clk    <= sclk_d;
      ser_latch  <= latch_d;
      oe_n       <= oe_d;
      row_addr   <= row_d;
      frame_done <= frame_d;
      in_ready   <= ready_d;
    end
  end

endmodule

// File: tb/tb_dot_row_serializer.sv
// Bench for dot_row_serializer: per-cycle scoreboard against a timeline model plus literal row checks.
module tb_dot_row_serializer;
  localparam int CD = 2;
  localparam int BC = 4;
`ifdef DOT_ROW_BLANK_EN
  localparam int BL = BC;
  localparam int PERIOD = 71;
`else
  localparam int BL = 0;
  localparam int PERIOD = 67;
`endif
  localparam int SH    = 32 * CD;
  localparam int LAT_K = SH + BL;
  localparam int L     = LAT_K + CD;

  logic clk = 0, rst_n = 0;
  logic [15:0] in_data = 0;
  logic [3:0]  in_sel = 0;
  logic in_valid = 0;
  logic in_ready, ser_dout, ser_clk, ser_latch, oe_n, frame_done;
  logic [3:0] row_addr;

  dot_row_serializer #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .ser_dout(ser_dout), .ser_clk(ser_clk), .ser_latch(ser_latch),
    .oe_n(oe_n), .row_addr(row_addr), .frame_done(frame_done));

  always #5 clk = ~clk;

  int checks = 0, fails = 0, cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference: a row is a fixed timeline of L cycles after the accept edge.
  logic busy = 0, lit = 0;
  int   k = 0, n_acc = 0;
  logic [15:0] dat_m = 0;
  logic [3:0]  sel_m = 0, row_m = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 0; k <= 0; lit <= 0; row_m <= 0;
    end else if (busy) begin
      k <= k + 1;
      if (k + 1 == LAT_K) row_m <= sel_m;
      if (k + 1 == L) begin busy <= 0; lit <= 1; end
    end else if (in_valid) begin
      busy <= 1; k <= 0; dat_m <= in_data; sel_m <= in_sel; n_acc <= n_acc + 1;
    end
  end

  // Observation state
  int rises = 0, latch_cnt = 0, frames = 0, frame_row = -1, rdy_rise = 0;
  logic [15:0] bits = 0;
  int acc_q[$];
  int row_q[$];
  logic prev_sclk = 0, prev_latch = 0, prev_rdy = 1;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("in_ready", in_ready, !busy);
      chk("ser_clk", ser_clk, busy && k < SH && (k % (2*CD)) >= CD);
      chk("ser_latch", ser_latch, busy && k >= LAT_K);
      chk("oe_n", oe_n, (busy && k >= SH && BL > 0) ? 1'b1 : !lit);
      chk("row_addr", row_addr, row_m);
      chk("frame_done", frame_done, busy && k == LAT_K && sel_m == 4'd15);
      if (busy && k < SH) chk("ser_dout", ser_dout, dat_m[15 - k/(2*CD)]);
      if (ser_clk && !prev_sclk) begin rises++; bits = {bits[14:0], ser_dout}; end
      if (ser_latch) latch_cnt++;
      if (ser_latch && !prev_latch) row_q.push_back(int'(row_addr));
      if (frame_done) begin frames++; frame_row = int'(row_addr); end
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (in_ready && !prev_rdy) rdy_rise = cyc + 1;
    end
    prev_sclk = ser_clk; prev_latch = ser_latch; prev_rdy = in_ready;
  end

  task automatic wait_acc(input int n0);
    for (int i = 0; i < 500 && n_acc == n0; i++) begin @(posedge clk); #1; end
    chk("accept_timeout", n_acc != n0, 1'b1);
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] s);
    int n0;
    @(posedge clk); #1;
    n0 = n_acc;
    in_valid = 1; in_data = d; in_sel = s;
    wait_acc(n0);
    in_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) begin @(posedge clk); #1; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic clr_obs();
    @(posedge clk); #1;
    rises = 0; bits = 0; latch_cnt = 0;
  endtask

  initial begin
    logic [15:0] d;
    int a0, f0, r0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_oe_n", oe_n, 1'b1);
    chk("rst_row", row_addr, 4'd0);
    chk("rst_sclk", ser_clk, 1'b0);
    chk("rst_latch", ser_latch, 1'b0);
    chk("rst_dout", ser_dout, 1'b0);
    @(posedge clk); #1 rst_n = 1;

    // idle: no shift-clock activity
    clr_obs();
    repeat (200) @(posedge clk);
    #1 chk("idle_rises", rises, 0);

    // single row at defaults
    clr_obs();
    send(16'hFFA4, 4'd3);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("row1_bits", bits, 16'hFFA4);
    chk("row1_rises", rises, 16);
    chk("row1_latch_len", latch_cnt, CD);
    chk("row1_row", row_addr, 4'd3);
    chk("row1_ready_lat", rdy_rise - acc_q[$], PERIOD);
    chk("row1_oe_lit", oe_n, 1'b0);

    // back-to-back frame with in_valid held high
    a0 = acc_q.size(); f0 = frames; r0 = row_q.size();
    @(posedge clk); #1;
    in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      int n0;
      n0 = n_acc;
      in_data = 16'($urandom); in_sel = 4'(i);
      wait_acc(n0);
    end
    in_valid = 0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_accepts", acc_q.size() - a0, 16);
    for (int j = a0; j + 1 < acc_q.size(); j++) chk("b2b_gap", acc_q[j+1] - acc_q[j], PERIOD);
    chk("frame_count", frames - f0, 1);
    chk("frame_row", frame_row, 15);
    for (int j = 0; j < 16 && r0 + j < row_q.size(); j++) chk("row_seq", row_q[r0 + j], j);

    // upstream noise while busy must not leak into the row
    clr_obs();
    d = 16'($urandom);
    a0 = acc_q.size();
    send(d, 4'd9);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); in_data = 16'($urandom); in_sel = 4'($urandom);
    end
    in_valid = 0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("noise_bits", bits, d);
    chk("noise_row", row_addr, 4'd9);
    chk("noise_accepts", acc_q.size() - a0, 1);

    // asynchronous reset during bit 7
    send(16'($urandom), 4'd4);
    for (int i = 0; i < 500 && !(busy && k == 7*2*CD + 1); i++) begin @(posedge clk); #1; end
    chk("bit7_reached", busy && k == 7*2*CD + 1, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_sclk", ser_clk, 1'b0);
    chk("arst_dout", ser_dout, 1'b0);
    chk("arst_latch", ser_latch, 1'b0);
    chk("arst_oe_n", oe_n, 1'b1);
    chk("arst_row", row_addr, 4'd0);
    chk("arst_frame", frame_done, 1'b0);
    @(posedge clk); #1 rst_n = 1;
    clr_obs();
    send(16'h0024, 4'd6);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_bits", bits, 16'h0024);
    chk("post_rst_rises", rises, 16);
    chk("post_rst_row", row_addr, 4'd6);

    // random rows with random gaps
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      send(16'($urandom), 4'($urandom));
    end
    wait_idle();
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
